mvm_host_driver: RTL and testbench
==================================

MVM_HOST_DRIVER -- requirements
Module: mvm_host_driver

Interface
REQ-001 Parameter K, default 8: matrix dimension; the matrix is K x K and the vector has K elements.
REQ-002 Parameter B, default 8: signed data width; results are 2*B bits.
REQ-003 Parameter TIMEOUT, default 1024: maximum number of cycles spent waiting for mvm_done.
REQ-004 clk  input  1  the single clock; all logic is clocked on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  host write strobe into the local operand buffers.
REQ-007 wr_sel  input  1  buffer select: 0 = matrix buffer, 1 = vector buffer.
REQ-008 wr_addr  input  $clog2(K*K)  write address; row-major for the matrix; only the low bits are used for the vector.
REQ-009 wr_data  input  B  signed operand word.
REQ-010 go  input  1  one-cycle request to run one MVM transaction.
REQ-011 busy  output  1  high from the cycle after an accepted go until the transaction ends.
REQ-012 mvm_loadMatrix  output  1  load-matrix marker pulse to the MVM.
REQ-013 mvm_loadVector  output  1  load-vector marker pulse to the MVM.
REQ-014 mvm_start  output  1  compute-start pulse to the MVM.
REQ-015 mvm_data_in  output  B  operand stream to the MVM.
REQ-016 mvm_done  input  1  completion flag from the MVM.
REQ-017 mvm_data_out  input  2*B  result stream from the MVM.
REQ-018 res_valid  output  1  the captured result word is valid this cycle.
REQ-019 res_idx  output  $clog2(K)  index i of y[i].
REQ-020 res_data  output  2*B  captured y[i].
REQ-021 error  output  1  sticky timeout flag; cleared by the next accepted go or by reset.

Function
REQ-022 The FSM states are IDLE, LDM, MSTR, GAP1, LDV, VSTR, GAP2, START, WAITD, COLL.
REQ-023 IDLE: go=1 moves to LDM; go is ignored in every other state.
REQ-024 LDM: one cycle with mvm_loadMatrix=1.
REQ-025 MSTR: K*K consecutive cycles, with matrix[n] (n = 0..K*K-1, row-major) driven on mvm_data_in in cycle n.
REQ-026 GAP1 and GAP2: one cycle each with all strobes low.
REQ-027 LDV: one cycle with mvm_loadVector=1.
REQ-028 VSTR: K cycles driving vector[0..K-1].
REQ-029 START: one cycle with mvm_start=1.
REQ-030 WAITD: the block waits for mvm_done=1, counting cycles.
REQ-031 WAITD timeout: if the count reaches TIMEOUT without done, the block sets error=1 and returns to IDLE with no results emitted.
REQ-032 WAITD exit: in the cycle mvm_done is first seen high (cycle d), the block moves to COLL.
REQ-033 COLL: in cycles d+1 .. d+K, the block samples mvm_data_out and presents the sample as res_data with res_valid=1 and res_idx=0..K-1, registered and appearing one cycle after the sample; it then returns to IDLE.
REQ-034 mvm_data_in holds its last driven value outside MSTR/VSTR; mvm_data_in is 0 after reset.
REQ-035 Host writes are accepted only in IDLE; writes while busy are dropped.
REQ-036 A write and go asserted in the same IDLE cycle: the write completes first and is used by that transaction.
REQ-037 A vector write with wr_addr >= K is dropped.
REQ-038 res_data is passed through unmodified, with no sign extension or truncation.
REQ-039 busy=0 only in IDLE; busy rises the cycle after go.
REQ-040 Total cycles from go to the first mvm_data_in matrix word = 2.

Reset
REQ-041 Reset forces IDLE, busy=0, error=0, res_valid=0, res_idx=0, res_data=0, all MVM strobes 0, mvm_data_in=0, and the counters to 0.
REQ-042 Reset mid-transaction aborts immediately, with no further strobes or results.
REQ-043 Operand buffer contents are not cleared by reset.

Verification
REQ-044 Nominal run: load A[r][c]=r+c and x[i]=1, pulse go, model MVM asserts done 10 cycles after start -> loadMatrix, 64 words 0..14 in row-major order, loadVector, 8 ones, and a start pulse, each with exact spacing; res_idx 0..7 carries y[i]=8*i+28.
REQ-045 Signed values: A all 0x80 (-128), x all 0x7F (127) -> every result equals 16'h8100 (-32512 repeated); this is the MVM model output passed through.
REQ-046 go while busy: pulse go during MSTR -> ignored; exactly one transaction occurs and the stream is unchanged.
REQ-047 Timeout: mvm_done held low -> error=1 exactly TIMEOUT cycles after START, no res_valid, return to IDLE; the next go clears error.
REQ-048 Reset mid-operation: reset asserted during VSTR -> all outputs 0 the next cycle; a subsequent go replays the full sequence from LDM using the retained buffers.
REQ-049 Write blocking: wr_en during WAITD with new data -> the buffers are unchanged, and the next run streams the old values.

Source files
------------

// File: rtl/mvm_host_driver.sv
// mvm_host_driver: host-side sequencer for a K x K matrix-vector multiply unit.
// Buffers a matrix and a vector written by the host, then on 'go' streams them
// to the MVM (loadMatrix, K*K words, gap, loadVector, K words, gap, start),
// waits for mvm_done with a timeout, and captures K result words.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data  host operand writes (sel 0 = matrix, 1 = vector)
//   go                      one-cycle request to run a transaction
//   busy                    transaction in progress
//   mvm_loadMatrix/mvm_loadVector/mvm_start/mvm_data_in  strobes and stream to MVM
//   mvm_done/mvm_data_out   completion flag and result stream from MVM
//   res_valid/res_idx/res_data    captured result y[res_idx]
//   error                   sticky timeout flag, cleared by the next accepted go
module mvm_host_driver #(
  parameter int unsigned K       = 8,
  parameter int unsigned B       = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(K*K)-1:0] wr_addr,
  input  logic [B-1:0]           wr_data,
  input  logic                   go,
  output logic                   busy,
  output logic                   mvm_loadMatrix,
  output logic                   mvm_loadVector,
  output logic                   mvm_start,
  output logic [B-1:0]           mvm_data_in,
  input  logic                   mvm_done,
  input  logic [2*B-1:0]         mvm_data_out,
  output logic                   res_valid,
  output logic [$clog2(K)-1:0]   res_idx,
  output logic [2*B-1:0]         res_data,
  output logic                   error
);

  localparam int unsigned AW   = $clog2(K*K);
  localparam int unsigned IW   = $clog2(K);
  localparam int unsigned CMAX = (K*K > TIMEOUT) ? K*K : TIMEOUT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] LDM   = 4'd1;
  localparam logic [3:0] MSTR  = 4'd2;
  localparam logic [3:0] GAP1  = 4'd3;
  localparam logic [3:0] LDV   = 4'd4;
  localparam logic [3:0] VSTR  = 4'd5;
  localparam logic [3:0] GAP2  = 4'd6;
  localparam logic [3:0] START = 4'd7;
  localparam logic [3:0] WAITD = 4'd8;
  localparam logic [3:0] COLL  = 4'd9;

  logic [3:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          timeout_hit;

  logic [B-1:0] mat [K*K];
  logic [B-1:0] vec [K];

  // Operand buffers: writable only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE)) begin
      if (!wr_sel) begin
        mat[wr_addr] <= wr_data;
      end else if (wr_addr < AW'(K)) begin
        vec[IW'(wr_addr)] <= wr_data;
      end
    end
  end

  // State and shared phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state; cnt indexes the stream phases, and in WAITD counts cycles since START.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_d = LDM;
          cnt_d   = '0;
        end
      end
      LDM: begin
        state_d = MSTR;
        cnt_d   = '0;
      end
      MSTR: begin
        if (cnt == CW'(K*K - 1)) begin
          state_d = GAP1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      GAP1: state_d = LDV;
      LDV: begin
        state_d = VSTR;
        cnt_d   = '0;
      end
      VSTR: begin
        if (cnt == CW'(K - 1)) begin
          state_d = GAP2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      GAP2: state_d = START;
      START: begin
        state_d = WAITD;
        cnt_d   = CW'(1);
      end
      WAITD: begin
        if (mvm_done) begin
          state_d = COLL;
          cnt_d   = '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          cnt_d       = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      COLL: begin
        if (cnt == CW'(K - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy           <= 1'b0;
      mvm_loadMatrix <= 1'b0;
      mvm_loadVector <= 1'b0;
      mvm_start      <= 1'b0;
      mvm_data_in    <= '0;
      res_valid      <= 1'b0;
      res_idx        <= '0;
      res_data       <= '0;
      error          <= 1'b0;
    end else begin
      busy           <= (state_d != IDLE);
      mvm_loadMatrix <= (state_d == LDM);
      mvm_loadVector <= (state_d == LDV);
      mvm_start      <= (state_d == START);
      if (state_d == MSTR) begin
        mvm_data_in <= mat[AW'(cnt_d)];
      end else if (state_d == VSTR) begin
        mvm_data_in <= vec[IW'(cnt_d)];
      end
      // Result capture lags the sampled MVM word by one cycle.
      res_valid <= (state == COLL);
      if (state == COLL) begin
        res_idx  <= IW'(cnt);
        res_data <= mvm_data_out;
      end
      if (timeout_hit) begin
        error <= 1'b1;
      end else if ((state == IDLE) && go) begin
        error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mvm_host_driver.sv
// Bench for mvm_host_driver: a timeline model (offsets from the go cycle) predicts
// every output each cycle; an MVM stub answers with done and result words.
module tb_mvm_host_driver;

  localparam int K     = 8;
  localparam int B     = 8;
  localparam int TO    = 1024;
  localparam int KK    = K * K;
  localparam int S_OFF = KK + K + 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        go = 1'b0;
  logic        busy, mvm_loadMatrix, mvm_loadVector, mvm_start;
  logic [7:0]  mvm_data_in;
  logic        mvm_done = 1'b0;
  logic [15:0] mvm_data_out = '0;
  logic        res_valid;
  logic [2:0]  res_idx;
  logic [15:0] res_data;
  logic        error;

  mvm_host_driver #(.K(K), .B(B), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .go(go), .busy(busy), .mvm_loadMatrix(mvm_loadMatrix),
    .mvm_loadVector(mvm_loadVector), .mvm_start(mvm_start), .mvm_data_in(mvm_data_in),
    .mvm_done(mvm_done), .mvm_data_out(mvm_data_out), .res_valid(res_valid),
    .res_idx(res_idx), .res_data(res_data), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0, total = 0, bad = 0;
  logic [7:0]  mm [KK];
  logic [7:0]  mv [K];
  logic [15:0] y  [K];
  bit   act = 0, y_ovr = 0, err_e = 0, err_prev = 0;
  int   G = 0, lat = -1, pend_lat = -1;
  logic [7:0]  din_e = '0;
  int   start_seen = -1, first_rv = -1, err_rise = -1;
  logic [15:0] last_res = '0;

  function automatic int d_cyc();
    return G + S_OFF + lat;
  endfunction

  function automatic int idle_from();
    return (lat < 0) ? G + S_OFF + TO : G + S_OFF + lat + K + 1;
  endfunction

  function automatic bit m_idle();
    return !act || (cyc >= idle_from());
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  task automatic compute_y();
    for (int i = 0; i < K; i++) begin
      int acc;
      acc = 0;
      for (int j = 0; j < K; j++)
        acc += int'($signed(mm[i*K+j])) * int'($signed(mv[j]));
      y[i] = y_ovr ? 16'h8100 : 16'(acc);
    end
  endtask

  task automatic check(input bit was_rst);
    int o, d;
    bit e_rv;
    if (was_rst) begin
      din_e = '0;
      err_e = 0;
      cmp("rst_busy", busy, 0);
      cmp("rst_lm", mvm_loadMatrix, 0);
      cmp("rst_lv", mvm_loadVector, 0);
      cmp("rst_start", mvm_start, 0);
      cmp("rst_din", mvm_data_in, 0);
      cmp("rst_rv", res_valid, 0);
      cmp("rst_idx", res_idx, 0);
      cmp("rst_data", res_data, 0);
      cmp("rst_err", error, 0);
    end else begin
      o = cyc - G;
      d = d_cyc();
      if (act && o >= 2 && o <= KK + 1) din_e = mm[o-2];
      if (act && o >= KK + 4 && o <= KK + K + 3) din_e = mv[o-KK-4];
      if (act && o == 1) err_e = 0;
      if (act && lat < 0 && cyc == G + S_OFF + TO) err_e = 1;
      e_rv = act && lat >= 0 && cyc >= d + 2 && cyc <= d + K + 1;
      cmp("busy", busy, 32'(act && o >= 1 && cyc < idle_from()));
      cmp("loadMatrix", mvm_loadMatrix, 32'(act && o == 1));
      cmp("loadVector", mvm_loadVector, 32'(act && o == KK + 3));
      cmp("start", mvm_start, 32'(act && o == S_OFF));
      cmp("data_in", mvm_data_in, din_e);
      cmp("error", error, 32'(err_e));
      cmp("res_valid", res_valid, 32'(e_rv));
      if (e_rv) begin
        cmp("res_idx", res_idx, cyc - d - 2);
        cmp("res_data", res_data, y[cyc-d-2]);
      end
    end
    if (mvm_start) start_seen = cyc;
    if (res_valid && first_rv < 0) first_rv = cyc;
    if (res_valid) last_res = res_data;
    if (error && !err_prev) err_rise = cyc;
    err_prev = error;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit rst, input bit we, input bit ws, input logic [5:0] wa,
                      input logic [7:0] wd, input bit g);
    int d;
    bit idle;
    d = d_cyc();
    reset = rst; wr_en = we; wr_sel = ws; wr_addr = wa; wr_data = wd; go = g;
    mvm_done = act && lat >= 0 && cyc >= d && cyc <= d + K;
    mvm_data_out = (act && lat >= 0 && cyc >= d + 1 && cyc <= d + K) ? y[cyc-d-1] : 16'($urandom);
    idle = m_idle();
    if (rst) begin
      act = 0;
    end else begin
      if (we && idle) begin
        if (!ws) mm[wa] = wd;
        else if (int'(wa) < K) mv[wa[2:0]] = wd;
      end
      if (g && idle) begin
        act = 1; G = cyc; lat = pend_lat;
        compute_y();
      end
    end
    @(posedge clk); #1; cyc++;
    check(rst);
  endtask

  task automatic idle_step();
    step(0, 0, 0, '0, '0, 0);
  endtask

  task automatic wr(input bit ws, input int a, input int v);
    step(0, 1, ws, 6'(a), 8'(v), 0);
  endtask

  // mode 0 quiet, 1 random go/writes while busy, 2 go during MSTR and writes during WAITD
  task automatic run_tx(input int l, input int mode, input bit we, input bit ws,
                        input int wa, input int wd);
    pend_lat = l; start_seen = -1; first_rv = -1;
    step(0, we, ws, 6'(wa), 8'(wd), 1);
    for (int n = 0; n < 3000; n++) begin
      if (m_idle()) break;
      if (mode == 1)
        step(0, 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), ($urandom % 6) == 0);
      else if (mode == 2 && cyc == G + 6)
        step(0, 0, 0, '0, '0, 1);
      else if (mode == 2 && cyc > G + S_OFF)
        step(0, 1, cyc[0], 6'(cyc), ~mm[6'(cyc)], 0);
      else
        idle_step();
    end
    total++;
    if (!m_idle()) begin
      bad++;
      $display("FAIL tx_budget cyc=%0d got=busy want=idle", cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    step(1, 0, 0, '0, '0, 0);
    step(1, 0, 0, '0, '0, 0);
    idle_step();

    // Nominal: A[r][c]=r+c, x=1, last vector write shares the go cycle.
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) wr(0, r*K + c, r + c);
    for (int i = 0; i < K - 1; i++) wr(1, i, 1);
    run_tx(10, 0, 1, 1, K - 1, 1);
    for (int i = 0; i < K; i++) cmp("y_model_pin", y[i], 8*i + 28);
    cmp("start_latency_pin", start_seen - G, 77);
    cmp("done_to_res_pin", first_rv - start_seen, 12);
    cmp("last_res_pin", last_res, 16'd84);

    // go during MSTR ignored, writes during WAITD dropped; replay checks old data.
    run_tx(15, 2, 0, 0, 0, 0);
    run_tx(4, 0, 0, 0, 0, 0);

    // Signed operands; MVM stub returns 16'h8100, passed through unchanged.
    for (int a = 0; a < KK; a++) wr(0, a, 8'h80);
    for (int i = 0; i < K; i++) wr(1, i, 8'h7F);
    y_ovr = 1;
    run_tx(5, 0, 0, 0, 0, 0);
    y_ovr = 0;
    cmp("signed_res_pin", last_res, 16'h8100);

    // Timeout, then the next go clears error.
    run_tx(-1, 1, 0, 0, 0, 0);
    cmp("timeout_pin", err_rise - start_seen, TO);
    cmp("err_sticky_pin", error, 1);
    wr(0, 3, 8'h5A);
    run_tx(3, 0, 0, 0, 0, 0);
    cmp("err_cleared_pin", error, 0);

    // Reset during VSTR, then a full replay from retained buffers.
    pend_lat = 7;
    step(0, 0, 0, '0, '0, 1);
    for (int n = 0; n < 200 && cyc < G + KK + 6; n++) idle_step();
    step(1, 0, 0, '0, '0, 0);
    idle_step();
    run_tx(7, 0, 0, 0, 0, 0);

    // Randomized operands, latencies and busy-time noise.
    for (int t = 0; t < 6; t++) begin
      for (int w = 0; w < 12; w++)
        wr(1'($urandom), int'($urandom_range(0, KK - 1)), int'($urandom_range(0, 255)));
      run_tx(int'($urandom_range(1, 60)), 1, 0, 0, 0, 0);
      idle_step();
    end

    repeat (3) idle_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
